// File: rtl/dmem_lsu_pkg.sv
// Shared constants for the data-memory load/store unit and the memory block it feeds.
package dmem_lsu_pkg;

  localparam int DMEM_ADDR_W = 14;
  localparam int DMEM_DEPTH  = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/dmem_lsu.sv
// Single-request load/store unit: forms and range-checks the effective address,
// drives the data memory and returns load data over a valid/ready response channel.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_off,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              we_DM,
  output logic [DATA_W-1:0] dataDM,
  output logic [ADDR_W-1:0] addDM,
  input  logic [DATA_W-1:0] outDM,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  lsu_state_e        stateQ, stateNext;
  logic              weQ;
  logic [ADDR_W-1:0] eaAddr;
  logic              outOfRange;

  // Two's-complement offset added as raw bits: the sum wraps silently modulo 2^ADDR_W.
  assign eaAddr     = req_base + req_off;
  assign outOfRange = {1'b0, eaAddr} >= DEPTH_LIM;

  assign req_ready  = (stateQ == IDLE);
  assign resp_valid = (stateQ == RESP);
  // Gated by rst so a store caught by a reset edge never reaches the memory.
  assign we_DM      = (stateQ == ACCESS) && weQ && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      IDLE:    if (req_valid) stateNext = outOfRange ? RESP : ACCESS;
      ACCESS:  stateNext = weQ ? RESP : WAIT;
      WAIT:    stateNext = RESP;
      RESP:    if (resp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Request capture in IDLE and registered read data capture in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      addDM      <= '0;
      dataDM     <= '0;
      weQ        <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (req_valid) begin
            addDM      <= eaAddr;
            dataDM     <= req_wdata;
            weQ        <= req_we;
            resp_rdata <= '0;
            resp_err   <= outOfRange;
          end
        end
        WAIT: begin
          resp_rdata <= outDM;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: behavioural data memory, reference memory image and a response scoreboard.
module tb_dmem_lsu;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] req_off;
  logic [DATA_W-1:0] req_wdata;
  logic              we_DM;
  logic [DATA_W-1:0] dataDM;
  logic [ADDR_W-1:0] addDM;
  logic [DATA_W-1:0] outDM;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
    int                lat;
  } exp_t;

  exp_t              expQ[$];
  logic [DATA_W-1:0] mem    [0:DEPTH-1];
  logic [DATA_W-1:0] refMem [0:DEPTH-1];
  int                checks   = 0;
  int                failures = 0;
  int                weCount  = 0;
  logic [ADDR_W-1:0] weAddr   = '0;

  dmem_lsu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_base(req_base), .req_off(req_off), .req_wdata(req_wdata),
    .we_DM(we_DM), .dataDM(dataDM), .addDM(addDM), .outDM(outDM),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Memory with registered read port, as seen by the unit.
  always @(posedge clk) begin
    if (we_DM) mem[addDM[9:0]] <= dataDM;
    outDM <= mem[addDM[9:0]];
  end

  always @(negedge clk) begin
    if (we_DM) begin
      weCount <= weCount + 1;
      weAddr  <= addDM;
    end
  end

  task automatic predict(input logic we, input logic [ADDR_W-1:0] base, off,
                         input logic [DATA_W-1:0] wd, output exp_t e);
    logic [ADDR_W-1:0] ea;
    ea      = base + off;
    e.err   = (int'(ea) >= DEPTH);
    e.rdata = (e.err || we) ? '0 : refMem[ea[9:0]];
    e.lat   = e.err ? 1 : (we ? 2 : 3);
    if (we && !e.err) refMem[ea[9:0]] = wd;
  endtask

  // Issues one request and reports what the response looked like; no judging here.
  task automatic do_req(input logic we, input logic [ADDR_W-1:0] base, off,
                        input logic [DATA_W-1:0] wd, input logic consume,
                        output int lat, output logic [DATA_W-1:0] rd, output logic er);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_base = base; req_off = off; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata;
    er = resp_err;
    if (consume && resp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_base = '0; req_off = '0;
    req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, we_DM} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl got rdy/vld/err/we=%b want 1000", {req_ready, resp_valid, resp_err, we_DM});
    end
    checks++;
    if (resp_rdata !== '0 || addDM !== '0 || dataDM !== '0) begin
      failures++;
      $display("FAIL reset_data got rdata=%h add=%h data=%h want 0", resp_rdata, addDM, dataDM);
    end
  endtask

  task automatic test_store_load();
    exp_t e; int lat; logic [DATA_W-1:0] rd; logic er; int w0;
    w0 = weCount;
    predict(1'b1, 14'h010, 14'h002, 32'hDEADBEEF, e); expQ.push_back(e);
    do_req(1'b1, 14'h010, 14'h002, 32'hDEADBEEF, 1'b1, lat, rd, er);
    e = expQ.pop_front();
    checks++;
    if (lat !== e.lat || er !== e.err || rd !== e.rdata) begin
      failures++;
      $display("FAIL store_resp got lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h", lat, er, rd, e.lat, e.err, e.rdata);
    end
    checks++;
    if (weCount - w0 !== 1 || weAddr !== 14'h012) begin
      failures++;
      $display("FAIL store_we got pulses=%0d addr=%h want 1 at 012", weCount - w0, weAddr);
    end
    predict(1'b0, 14'h010, 14'h002, '0, e); expQ.push_back(e);
    do_req(1'b0, 14'h010, 14'h002, '0, 1'b1, lat, rd, er);
    e = expQ.pop_front();
    checks++;
    if (lat !== e.lat || er !== e.err || rd !== e.rdata) begin
      failures++;
      $display("FAIL load_resp got lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h", lat, er, rd, e.lat, e.err, e.rdata);
    end
  endtask

  task automatic test_neg_offset();
    exp_t e; int lat; logic [DATA_W-1:0] rd; logic er;
    predict(1'b1, 14'h003, 14'h000, 32'h0BADF00D, e);
    do_req(1'b1, 14'h003, 14'h000, 32'h0BADF00D, 1'b1, lat, rd, er);
    predict(1'b0, 14'h005, 14'h3FFE, '0, e); expQ.push_back(e);
    do_req(1'b0, 14'h005, 14'h3FFE, '0, 1'b1, lat, rd, er);
    e = expQ.pop_front();
    checks++;
    if (lat !== e.lat || er !== e.err || rd !== e.rdata) begin
      failures++;
      $display("FAIL negoff_resp got lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h", lat, er, rd, e.lat, e.err, e.rdata);
    end
    checks++;
    if (addDM !== 14'h003) begin
      failures++;
      $display("FAIL negoff_addr got %h want 003", addDM);
    end
  endtask

  task automatic test_out_of_range();
    exp_t e; int lat; logic [DATA_W-1:0] rd; logic er; int w0;
    predict(1'b1, 14'h3FF, 14'h000, 32'h77777777, e);
    do_req(1'b1, 14'h3FF, 14'h000, 32'h77777777, 1'b1, lat, rd, er);
    w0 = weCount;
    predict(1'b0, 14'h3FF, 14'h001, '0, e); expQ.push_back(e);
    do_req(1'b0, 14'h3FF, 14'h001, '0, 1'b1, lat, rd, er);
    e = expQ.pop_front();
    checks++;
    if (lat !== e.lat || er !== e.err || rd !== e.rdata) begin
      failures++;
      $display("FAIL oor_load got lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h", lat, er, rd, e.lat, e.err, e.rdata);
    end
    // A store to an out-of-range address must not touch memory either.
    predict(1'b1, 14'h3FFF, 14'h3FFF, 32'hCAFECAFE, e); expQ.push_back(e);
    do_req(1'b1, 14'h3FFF, 14'h3FFF, 32'hCAFECAFE, 1'b1, lat, rd, er);
    e = expQ.pop_front();
    checks++;
    if (lat !== e.lat || er !== e.err || rd !== e.rdata) begin
      failures++;
      $display("FAIL oor_store got lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h", lat, er, rd, e.lat, e.err, e.rdata);
    end
    checks++;
    if (weCount !== w0 || mem[10'h3FF] !== refMem[10'h3FF]) begin
      failures++;
      $display("FAIL oor_nowrite got pulses=%0d mem3FF=%h want 0 and %h", weCount - w0, mem[10'h3FF], refMem[10'h3FF]);
    end
  endtask

  task automatic test_backpressure();
    exp_t e; int lat; logic [DATA_W-1:0] rd; logic er; int w0;
    w0 = weCount;
    resp_ready = 1'b0;
    predict(1'b0, 14'h012, 14'h000, '0, e);
    do_req(1'b0, 14'h012, 14'h000, '0, 1'b0, lat, rd, er);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== e.rdata || resp_err !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got vld=%b rdy=%b rd=%h err=%b want 1 0 %h 0", i, resp_valid, req_ready, resp_rdata, resp_err, e.rdata);
      end
      if (i == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_base = 14'h012; req_off = '0; req_wdata = 32'hFFFFFFFF;
      end else begin
        req_valid = 1'b0;
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || weCount !== w0 || mem[10'h012] !== refMem[10'h012]) begin
      failures++;
      $display("FAIL bp_release got vld=%b rdy=%b pulses=%0d mem=%h want 0 1 0 %h", resp_valid, req_ready, weCount - w0, mem[10'h012], refMem[10'h012]);
    end
  endtask

  task automatic test_reset_access();
    exp_t e; int lat; logic [DATA_W-1:0] rd; logic er;
    predict(1'b1, 14'h020, 14'h000, 32'hA5A5A5A5, e);
    do_req(1'b1, 14'h020, 14'h000, 32'hA5A5A5A5, 1'b1, lat, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_base = 14'h020; req_off = '0; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (we_DM !== 1'b0) begin
      failures++;
      $display("FAIL rst_access_we got %b want 0", we_DM);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({req_ready, resp_valid, resp_err, we_DM} !== 4'b1000 || resp_rdata !== '0 || addDM !== '0 || dataDM !== '0) begin
      failures++;
      $display("FAIL rst_access_outs got rdy/vld/err/we=%b rd=%h add=%h data=%h want 1000 0 0 0", {req_ready, resp_valid, resp_err, we_DM}, resp_rdata, addDM, dataDM);
    end
    predict(1'b0, 14'h020, 14'h000, '0, e); expQ.push_back(e);
    do_req(1'b0, 14'h020, 14'h000, '0, 1'b1, lat, rd, er);
    e = expQ.pop_front();
    checks++;
    if (lat !== e.lat || er !== e.err || rd !== e.rdata) begin
      failures++;
      $display("FAIL rst_access_load got lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h", lat, er, rd, e.lat, e.err, e.rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] bases [4] = '{14'h030, 14'h030, 14'h031, 14'h031};
    logic [DATA_W-1:0] wdats [4] = '{32'h11112222, 32'h0, 32'h33334444, 32'h0};
    int got = 0;
    expQ.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          exp_t e; int n;
          @(negedge clk);
          req_valid = 1'b1; req_we = (i % 2 == 0); req_base = bases[i];
          req_off = '0; req_wdata = wdats[i];
          n = 0;
          while (!req_ready && n < 20) begin @(negedge clk); n++; end
          predict(req_we, bases[i], '0, wdats[i], e);
          expQ.push_back(e);
          @(posedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
      end
      begin
        logic prevWe = 1'b0;
        for (int c = 0; c < 60 && got < 4; c++) begin
          @(negedge clk);
          checks++;
          if ((req_ready && resp_valid) || (prevWe && we_DM)) begin
            failures++;
            $display("FAIL b2b_overlap cyc=%0d got rdy=%b vld=%b we=%b prevWe=%b", c, req_ready, resp_valid, we_DM, prevWe);
          end
          prevWe = we_DM;
          if (resp_valid && resp_ready) begin
            exp_t e;
            checks++;
            if (expQ.size() == 0) begin
              failures++;
              $display("FAIL b2b_unexpected got rd=%h err=%b want no response", resp_rdata, resp_err);
            end else begin
              e = expQ.pop_front();
              if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                failures++;
                $display("FAIL b2b_resp%0d got rd=%h err=%b want rd=%h err=%b", got, resp_rdata, resp_err, e.rdata, e.err);
              end
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got !== 4) begin
      failures++;
      $display("FAIL b2b_count got %0d responses want 4", got);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_neg_offset();
    test_out_of_range();
    test_backpressure();
    test_reset_access();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
